// File: rtl/regfile_write_arbiter.sv
// Two-port round-robin write arbiter for the register file.
// Produces a registered write-data bus and one-hot enable, suppressing hardware-owned registers.
module regfile_write_arbiter #(
  parameter int unsigned          NUM_REGS     = 16,
  parameter int unsigned          DATA_W       = 16,
  parameter logic [NUM_REGS-1:0]  PROTECT_MASK = NUM_REGS'(16'h8000)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        a_valid,
  output logic                        a_ready,
  input  logic [$clog2(NUM_REGS)-1:0] a_addr,
  input  logic [DATA_W-1:0]           a_data,
  input  logic                        b_valid,
  output logic                        b_ready,
  input  logic [$clog2(NUM_REGS)-1:0] b_addr,
  input  logic [DATA_W-1:0]           b_data,
  input  logic                        hold,
  input  logic                        clr_err,
  output logic [DATA_W-1:0]           aluBus,
  output logic [NUM_REGS-1:0]         regEn,
  output logic                        grant_last,
  output logic                        prot_err
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  typedef enum logic {PREF_A, PREF_B} ptr_t;

  ptr_t                ptr, ptrNext;
  logic                grantA, grantB, anyGrant;
  logic [AW-1:0]       selAddr;
  logic [DATA_W-1:0]   selData;
  logic [NUM_REGS-1:0] onehot, enNext;
  logic                protHit;

  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    // Readies stay low while reset is asserted so nothing is consumed and then dropped.
    if (!reset && !hold) begin
      if (a_valid && (!b_valid || ptr == PREF_A)) grantA = 1'b1;
      else if (b_valid)                           grantB = 1'b1;
    end
    anyGrant = grantA | grantB;
    selAddr  = grantB ? b_addr : a_addr;
    selData  = grantB ? b_data : a_data;
    onehot   = {{(NUM_REGS-1){1'b0}}, 1'b1} << selAddr;
    enNext   = anyGrant ? (onehot & ~PROTECT_MASK) : '0;
    protHit  = anyGrant && (|(onehot & PROTECT_MASK));
    ptrNext  = ptr;
    if (grantA)      ptrNext = PREF_B;
    else if (grantB) ptrNext = PREF_A;
  end

  assign a_ready = grantA;
  assign b_ready = grantB;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= PREF_A;
      regEn      <= '0;
      aluBus     <= '0;
      grant_last <= 1'b0;
      prot_err   <= 1'b0;
    end else begin
      ptr   <= ptrNext;
      regEn <= enNext;
      if (anyGrant) begin
        aluBus     <= selData;
        grant_last <= grantB;
      end
      if (protHit)      prot_err <= 1'b1;
      else if (clr_err) prot_err <= 1'b0;
    end
  end

endmodule
